calc_mul_core: RTL and testbench

Arithmetic stage directly downstream of the parameter loader. On a rising edge of `start_calc` it captures the signed operand pair `a0`/`a1` and computes `a0 * a1` with an iterative 32-step shift-add multiplier. It holds `core_busy` high for the whole computation and presents a 32-bit result with a one-cycle valid pulse. `core_busy` is the back-pressure signal the loader watches before it accepts new pin data.

---
 rtl/calc_mul_core.sv | 128 ++++++++++++
 tb/tb_calc_mul_core.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_mul_core.sv
// calc_mul_core: signed 32x32 multiply using a 32-step shift-add datapath.
// A rising edge of start_calc in IDLE captures the operand magnitudes and
// the product sign. The core then runs 32 shift-add steps (MUL) and one
// sign/overflow step (FIX). Finally it pulses result_valid and drops
// core_busy (DONE).
//
// Handshake: start_calc is a level; only its low-to-high transition
// (start_calc & ~start_d) starts work, and only while IDLE. core_busy is
// high from the cycle after the accepted edge until the cycle after
// result_valid. result_valid is a single-cycle pulse that coincides with the
// last core_busy cycle. result and overflow hold until the next completion.
//
// Optional build macro: CALC_MUL_SAT_EN -- saturate result on overflow
// instead of two's-complement wrap. overflow is the same in both builds.
// dbg_state exposes the FSM state (0=IDLE, 1=MUL, 2=FIX, 3=DONE).
module calc_mul_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic        start_calc,
  output logic        core_busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        overflow,
  output logic [1:0]  dbg_state
);

  localparam int MUL_STEPS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic        start_d;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        sign;
  logic [63:0] acc;
  logic [4:0]  cnt;

  logic        start_edge;
  logic [31:0] abs_a0;
  logic [31:0] abs_a1;
  logic [63:0] add_term;
  logic        p_ovf;
  logic [31:0] p_wrap;
  logic [31:0] fix_result;

  assign start_edge = start_calc & ~start_d;
  assign dbg_state  = state;

  // Operand magnitudes, shifted partial product, and the FIX-step result.
  always_comb begin
    abs_a0   = a0[31] ? (~a0 + 32'd1) : a0;
    abs_a1   = a1[31] ? (~a1 + 32'd1) : a1;
    add_term = {32'd0, mcand} << cnt;
    // Negative products may reach magnitude 2^31; positive ones only 2^31-1.
    p_ovf    = sign ? (acc > 64'h0000_0000_8000_0000)
                    : (acc > 64'h0000_0000_7FFF_FFFF);
    p_wrap   = sign ? (~acc[31:0] + 32'd1) : acc[31:0];
`ifdef CALC_MUL_SAT_EN
    if (p_ovf) fix_result = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else       fix_result = p_wrap;
`else
    fix_result = p_wrap;
`endif
  end

  // Start-edge history, updated every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_d <= 1'b0;
    else        start_d <= start_calc;
  end

  // Control FSM, shift-add datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mcand        <= '0;
      mplier       <= '0;
      sign         <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      core_busy    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            mcand     <= abs_a0;
            mplier    <= abs_a1;
            sign      <= a0[31] ^ a1[31];
            acc       <= '0;
            cnt       <= '0;
            core_busy <= 1'b1;
            state     <= S_MUL;
          end
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + add_term;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(MUL_STEPS - 1)) state <= S_FIX;
        end
        S_FIX: begin
          result       <= fix_result;
          overflow     <= p_ovf;
          result_valid <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          result_valid <= 1'b0;
          core_busy    <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_mul_core.sv
// Testbench for calc_mul_core: table vectors, random vectors checked against
// a native signed multiply, handshake and reset sequences. Expected
// {overflow,result} pairs flow through a scoreboard queue.
module tb_calc_mul_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] a0;
  logic [31:0] a1;
  logic        start_calc;
  logic        core_busy;
  logic [31:0] result;
  logic        result_valid;
  logic        overflow;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;

  logic [32:0] exp_q[$];

  typedef struct {
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] res_wrap;
    logic [31:0] res_sat;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  calc_mul_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a0           (a0),
    .a1           (a1),
    .start_calc   (start_calc),
    .core_busy    (core_busy),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: compare each result_valid pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      valid_cnt++;
      check("sb_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("result", {32'd0, result}, {32'd0, e[31:0]});
        check("overflow", {63'd0, overflow}, {63'd0, e[32]});
      end
    end
  end

  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    logic ovf;
    logic [31:0] r;
    p = 64'($signed(x)) * 64'($signed(y));
    ovf = (p > 64'sh0000_0000_7FFF_FFFF) || (p < -64'sh0000_0000_8000_0000);
    r = p[31:0];
`ifdef CALC_MUL_SAT_EN
    if (ovf) r = p[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ovf, r};
  endfunction

  // one calculation with start pulse; checks busy length and valid position
  task automatic run_calc(input logic [31:0] x, input logic [31:0] y, input logic [32:0] e);
    int busy_n;
    int valid_at;
    @(negedge clk);
    a0 = x;
    a1 = y;
    start_calc = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    busy_n = 0;
    valid_at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) start_calc = 1'b0;
      if (!core_busy) break;
      busy_n++;
      if (result_valid) valid_at = i;
    end
    check("busy_len", 64'(busy_n), 64'd34);
    check("valid_pos", 64'(valid_at), 64'd33);
  endtask

  initial begin
    int v0;
    int late_busy;
    int busy_n;
    logic [32:0] e;
    logic [31:0] rx, ry;

    vecs[0]  = '{32'd3,        32'd5,        32'd15,        32'd15,        1'b0};
    vecs[1]  = '{-32'sd7,      32'd6,        32'hFFFF_FFD6, 32'hFFFF_FFD6, 1'b0};
    vecs[2]  = '{32'd0,        -32'sd123,    32'd0,         32'd0,         1'b0};
    vecs[3]  = '{32'h7FFF_FFFF, 32'd2,       32'hFFFF_FFFE, 32'h7FFF_FFFF, 1'b1};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[5]  = '{32'h8000_0000, 32'd1,       32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{32'h0001_0000, 32'h0000_8000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[7]  = '{32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[9]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};

    // reset
    rst_n = 1'b0;
    start_calc = 1'b0;
    a0 = '0;
    a1 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, core_busy}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_valid", {63'd0, result_valid}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table vectors
    for (int i = 0; i < 11; i++) begin
`ifdef CALC_MUL_SAT_EN
      e = {vecs[i].ovf, vecs[i].res_sat};
`else
      e = {vecs[i].ovf, vecs[i].res_wrap};
`endif
      run_calc(vecs[i].a0, vecs[i].a1, e);
    end

    // random vectors against native multiply
    for (int i = 0; i < 12; i++) begin
      rx = $urandom;
      ry = (i % 2 == 0) ? $urandom : (32'($urandom_range(0, 200)) - 32'd100);
      run_calc(rx, ry, model(rx, ry));
    end

    // start held high through and 10 cycles past completion
    @(negedge clk);
    a0 = 32'd11;
    a1 = 32'd13;
    start_calc = 1'b1;
    exp_q.push_back(model(32'd11, 32'd13));
    v0 = valid_cnt;
    late_busy = 0;
    @(posedge clk);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i >= 34 && core_busy) late_busy++;
    end
    check("hold_valid_count", 64'(valid_cnt - v0), 64'd1);
    check("hold_busy_after", 64'(late_busy), 64'd0);
    start_calc = 1'b0;
    repeat (2) @(negedge clk);

    // second rising edge during busy is ignored
    a0 = -32'sd5;
    a1 = 32'd9;
    start_calc = 1'b1;
    exp_q.push_back(model(-32'sd5, 32'd9));
    v0 = valid_cnt;
    busy_n = 0;
    @(posedge clk);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 9) start_calc = 1'b0;
      if (i == 10) begin
        a0 = 32'd100;
        start_calc = 1'b1;
      end
      if (i == 11) start_calc = 1'b0;
      if (core_busy) busy_n++;
    end
    check("reedge_valid_count", 64'(valid_cnt - v0), 64'd1);
    check("reedge_busy_len", 64'(busy_n), 64'd34);

    // new edge after busy falls starts a fresh calculation
    run_calc(32'd1000, -32'sd3, model(32'd1000, -32'sd3));

    // reset in the middle of a calculation
    @(negedge clk);
    a0 = 32'd77;
    a1 = 32'd77;
    start_calc = 1'b1;
    exp_q.push_back(model(32'd77, 32'd77));
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) start_calc = 1'b0;
    end
    check("pre_rst_busy", {63'd0, core_busy}, 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", {63'd0, core_busy}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_valid", {63'd0, result_valid}, 64'd0);
    check("abort_ovf", {63'd0, overflow}, 64'd0);
    check("abort_state", {62'd0, dbg_state}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cnt;
    late_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (core_busy) late_busy++;
    end
    check("post_rst_valid", 64'(valid_cnt - v0), 64'd0);
    check("post_rst_busy", 64'(late_busy), 64'd0);

    run_calc(32'd9, -32'sd9, model(32'd9, -32'sd9));

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
